// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and frame-length helper
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  function automatic int frame_len(int div, int parity_en, int stop_bits);
    return (1 + UART_DATA_BITS + parity_en + stop_bits) * div;
  endfunction
endpackage

// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: valid/ready byte stream into the UART transmitter
interface uart_tx_core_if;
  import uart_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [UART_DATA_BITS-1:0] in_data;
  modport master(output in_valid, in_data, input in_ready);
  modport slave(input in_valid, in_data, output in_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count and wrap-bit pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign empty = wp == rp;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core: FIFO-buffered 8-bit UART transmitter with optional parity
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DIV        = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_core_if.slave               bus,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int CW = $clog2(DIV);
  uart_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [UART_DATA_BITS-1:0] sr, sr_n, head;
  logic par, par_n, tx_n, pop, full, empty, tick;
  sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk, .rst, .push(bus.in_valid), .pop, .wdata(bus.in_data),
    .rdata(head), .count(fifo_count), .full, .empty
  );
  assign bus.in_ready = !full;
  assign busy = state != IDLE || !empty;
  assign tick = cnt == CW'(DIV - 1);
  always_comb begin
    state_n = state;
    pop = 1'b0;
    sr_n = sr;
    par_n = par;
    unique case (state)
      IDLE:   if (!empty) begin state_n = START; pop = 1'b1; end
      START:  if (tick) state_n = DATA;
      DATA:   if (tick) begin
        sr_n = {1'b0, sr[UART_DATA_BITS-1:1]};
        if (idx == 3'd7) state_n = PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (tick) state_n = STOP;
      STOP:   if (tick && idx == 3'(STOP_BITS - 1)) begin
        state_n = empty ? IDLE : START;
        pop = !empty;
      end
      default: state_n = IDLE;
    endcase
    // parity is fixed when the byte is loaded so the shifting register can't disturb it
    if (pop) begin
      sr_n = head;
      par_n = ^head ^ 1'(PARITY_ODD);
    end
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sr_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sr <= '0;
      par <= 1'b0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      sr <= sr_n;
      par <= par_n;
      tx <= tx_n;
      cnt <= (state_n != state || tick || state == IDLE) ? '0 : cnt + 1'b1;
      idx <= state_n != state ? '0 : idx + 3'(tick);
    end
  end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: table-driven and scoreboard checks over four configurations
module tb_uart_tx_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_core_if ia(), ib(), ic(), id();
  logic tx_a, tx_b, tx_c, tx_d, busy_a, busy_b, busy_c, busy_d;
  logic [2:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d;

  uart_tx_core #(.DIV(4), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave), .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a));
  uart_tx_core #(.DIV(4), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave), .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b));
  uart_tx_core #(.DIV(4), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .bus(ic.slave), .tx(tx_c), .busy(busy_c), .fifo_count(cnt_c));
  uart_tx_core #(.DIV(5), .FIFO_DEPTH(2), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_d (
    .clk(clk), .rst(rst), .bus(id.slave), .tx(tx_d), .busy(busy_d), .fifo_count(cnt_d));

  logic txv [4];
  logic busyv [4];
  logic rdyv [4];
  int cntv [4];
  assign txv[0] = tx_a;
  assign txv[1] = tx_b;
  assign txv[2] = tx_c;
  assign txv[3] = tx_d;
  assign busyv[0] = busy_a;
  assign busyv[1] = busy_b;
  assign busyv[2] = busy_c;
  assign busyv[3] = busy_d;
  assign rdyv[0] = ia.in_ready;
  assign rdyv[1] = ib.in_ready;
  assign rdyv[2] = ic.in_ready;
  assign rdyv[3] = id.in_ready;
  assign cntv[0] = int'(cnt_a);
  assign cntv[1] = int'(cnt_b);
  assign cntv[2] = int'(cnt_c);
  assign cntv[3] = int'(cnt_d);

  int divv [4] = '{4, 4, 4, 5};
  int nbv [4] = '{10, 11, 11, 12};
  int peen [4] = '{0, 1, 0, 1};
  int podd [4] = '{0, 0, 0, 1};

  typedef struct {int k; logic [11:0] f; bit contig;} exp_t;
  typedef struct {int k; logic [7:0] d; logic [11:0] f;} vec_t;
  exp_t q[$];
  int errs = 0;
  int checks = 0;

  function automatic logic [11:0] model(input int k, input logic [7:0] d);
    logic [11:0] f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    if (peen[k] != 0) f[9] = (^d) ^ (podd[k] != 0);
    return f;
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic [7:0] d);
    case (k)
      0: begin ia.in_valid = v; ia.in_data = d; end
      1: begin ib.in_valid = v; ib.in_data = d; end
      2: begin ic.in_valid = v; ic.in_data = d; end
      default: begin id.in_valid = v; id.in_data = d; end
    endcase
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic [11:0] f, input bit contig);
    int w = 0;
    while (!rdyv[k] && w < 500) begin @(negedge clk); w++; end
    if (!rdyv[k]) begin
      chk($sformatf("push_ready_timeout_dut%0d", k), 0, 1);
      return;
    end
    drive(k, 1'b1, d);
    @(posedge clk);
    q.push_back('{k, f, contig});
    @(negedge clk);
    drive(k, 1'b0, 8'h00);
  endtask

  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || busy_a || busy_b || busy_c || busy_d) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending_frames", q.size(), 0);
  endtask

  task automatic finish_frame(input int k, input logic [11:0] got, input int gap);
    logic [11:0] mask;
    int hit = -1;
    for (int i = 0; i < q.size(); i++) if (hit < 0 && q[i].k == k) hit = i;
    if (hit < 0) begin
      chk($sformatf("unexpected_frame_dut%0d", k), 1, 0);
      return;
    end
    mask = 12'((13'd1 << nbv[k]) - 13'd1);
    checks++;
    if ((got & mask) != (q[hit].f & mask)) begin
      errs++;
      $display("FAIL frame_dut%0d: got %03h expected %03h", k, got & mask, q[hit].f & mask);
    end
    if (q[hit].contig) chk($sformatf("contig_gap_dut%0d", k), gap, nbv[k] * divv[k]);
    q.delete(hit);
  endtask

  // line monitor: finds each start edge and samples the middle of every bit
  int cyc = 0;
  bit act [4] = '{0, 0, 0, 0};
  logic ptx [4] = '{1, 1, 1, 1};
  int mc [4];
  int lst [4] = '{0, 0, 0, 0};
  int gap [4];
  logic [11:0] got [4];
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 4; k++) begin
      if (rst) act[k] = 0;
      else if (!act[k]) begin
        if (ptx[k] && !txv[k]) begin
          act[k] = 1;
          mc[k] = 0;
          got[k] = '1;
          gap[k] = cyc - lst[k];
          lst[k] = cyc;
        end
      end else begin
        mc[k]++;
        if (mc[k] % divv[k] == divv[k] / 2) begin
          got[k][mc[k] / divv[k]] = txv[k];
          if (mc[k] / divv[k] == nbv[k] - 1) begin
            act[k] = 0;
            finish_frame(k, got[k], gap[k]);
          end
        end
      end
      ptx[k] = txv[k];
    end
  end

  initial begin
    vec_t tab [11];
    logic [7:0] burst [5];
    int w, pc, hi, bad;
    tab = '{
      '{0, 8'h5A, {3'b111, 8'h5A, 1'b0}},
      '{0, 8'h00, {3'b111, 8'h00, 1'b0}},
      '{0, 8'hFF, {3'b111, 8'hFF, 1'b0}},
      '{1, 8'h07, {2'b11, 1'b1, 8'h07, 1'b0}},
      '{1, 8'h03, {2'b11, 1'b0, 8'h03, 1'b0}},
      '{1, 8'h80, {2'b11, 1'b1, 8'h80, 1'b0}},
      '{2, 8'hFF, {3'b111, 8'hFF, 1'b0}},
      '{2, 8'h00, {3'b111, 8'h00, 1'b0}},
      '{3, 8'h07, {2'b11, 1'b0, 8'h07, 1'b0}},
      '{3, 8'hA5, {2'b11, 1'b1, 8'hA5, 1'b0}},
      '{3, 8'h01, {2'b11, 1'b0, 8'h01, 1'b0}}
    };
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int k = 0; k < 4; k++) drive(k, 1'b0, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_tx_dut%0d", k), int'(txv[k]), 1);
      chk($sformatf("reset_ready_dut%0d", k), int'(rdyv[k]), 1);
      chk($sformatf("reset_busy_dut%0d", k), int'(busyv[k]), 0);
      chk($sformatf("reset_count_dut%0d", k), cntv[k], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    push(0, 8'h5A, model(0, 8'h5A), 0);
    chk("lat_tx_before_pop", int'(tx_a), 1);
    chk("lat_count_after_push", cntv[0], 1);
    chk("lat_busy", int'(busy_a), 1);
    @(negedge clk);
    chk("lat_tx_start", int'(tx_a), 0);
    chk("lat_count_after_pop", cntv[0], 0);
    repeat (39) @(negedge clk);
    chk("single_busy_last_cycle", int'(busy_a), 1);
    chk("single_tx_stop", int'(tx_a), 1);
    @(negedge clk);
    chk("single_busy_fall", int'(busy_a), 0);

    for (int i = 0; i < 11; i++) push(tab[i].k, tab[i].d, tab[i].f, 0);
    drain();

    for (int i = 0; i < 5; i++) push(0, burst[i], model(0, burst[i]), i != 0);
    chk("burst_ready_low", int'(ia.in_ready), 0);
    chk("burst_count_full", cntv[0], 4);
    drive(0, 1'b1, 8'hC3);
    w = 0;
    pc = cntv[0];
    while (!ia.in_ready && w < 200) begin pc = cntv[0]; @(negedge clk); w++; end
    chk("full_ready_rise", int'(ia.in_ready), 1);
    chk("full_prev_count", pc, 4);
    chk("full_count_after_pop", cntv[0], 3);
    @(posedge clk);
    q.push_back('{0, model(0, 8'hC3), 1'b1});
    @(negedge clk);
    drive(0, 1'b0, 8'h00);
    drain();

    push(2, 8'hFF, model(2, 8'hFF), 0);
    push(2, 8'h00, model(2, 8'h00), 1);
    chk("stop2_start_low", int'(tx_c), 0);
    w = 0;
    while (!tx_c && w < 20) begin @(negedge clk); w++; end
    hi = 0;
    while (tx_c && hi < 100) begin hi++; @(negedge clk); end
    chk("stop2_high_period", hi, 40);
    drain();

    push(0, 8'hF7, model(0, 8'hF7), 0);
    push(0, 8'h11, model(0, 8'h11), 0);
    push(0, 8'h22, model(0, 8'h22), 0);
    chk("rst_queued_count", cntv[0], 2);
    repeat (16) @(negedge clk);
    chk("rst_pre_tx_bit3", int'(tx_a), 0);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_tx", int'(tx_a), 1);
    chk("rst_mid_count", cntv[0], 0);
    chk("rst_mid_busy", int'(busy_a), 0);
    chk("rst_mid_ready", int'(ia.in_ready), 1);
    rst = 1'b0;
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (!tx_a || busy_a) bad = 1;
    end
    chk("rst_no_further_frames", bad, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
